spi_target_sync: RTL and testbench

Synchronous SPI target that terminates the host SPI link on the PE side. It oversamples `spi_clk`, `spi_csn` and `spi_mosi` in the `clk` domain and decodes write and read frames. Frames become single-cycle register-bus requests, and read data is shifted back on `spi_miso`. It sits between the chip SPI pins and the PE configuration/register file.

---
 rtl/spi_target_sync.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_target_sync.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_sync.sv
// SPI target oversampled in the clk domain; turns write/read frames into one-cycle register-bus strobes.
// Define SPI_TARGET_ERR_CNT_EN to add the saturating err_cnt output.
module spi_target_sync #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata
`ifdef SPI_TARGET_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for CSN to fall
  // CMD   | shifting in the 2 opcode bits
  // ADDR  | shifting in address bits; read strobe on the last one
  // PAD   | turnaround bit, read data is loaded into the TX shifter
  // DATA  | shifting data in (write) or out on MISO (read)
  // DRAIN | frame finished or invalid; ignore SCK until CSN rises
  typedef enum logic [2:0] {IDLE, CMD, ADDR, PAD, DATA, DRAIN} state_e;

  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  logic [1:0]            sck_s_q, csn_s_q, mosi_s_q;
  logic                  sck_prev_q;
  logic [1:0]            flush_q;
  logic                  arm_q;
  logic                  sck_s, csn_s, mosi_s, rise, fall;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-2:0] data_sh_q, data_sh_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic                  err_inc;

  assign sck_s  = sck_s_q[1];
  assign csn_s  = csn_s_q[1];
  assign mosi_s = mosi_s_q[1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;

  // arm_q requires a genuine synchronized CSN high after reset, so a frame
  // interrupted by reset is not decoded from the middle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s_q    <= 2'b00;
      csn_s_q    <= 2'b11;
      mosi_s_q   <= 2'b00;
      sck_prev_q <= 1'b0;
      flush_q    <= 2'b00;
      arm_q      <= 1'b0;
    end else begin
      sck_s_q    <= {sck_s_q[0], spi_clk};
      csn_s_q    <= {csn_s_q[0], spi_csn};
      mosi_s_q   <= {mosi_s_q[0], spi_mosi};
      sck_prev_q <= sck_s;
      flush_q    <= {flush_q[0], 1'b1};
      arm_q      <= arm_q | (flush_q[1] & csn_s);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    err_inc   = 1'b0;
    if (rd_en_q) tx_d = reg_rdata;
    if (csn_s) begin
      // CSN high beats any same-cycle bit event, so a late CSN kills the strobe
      if (state_q != IDLE) begin
        state_d = IDLE;
        tx_d    = '0;
        miso_d  = 1'b0;
        if (state_q != DRAIN) err_inc = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_q) begin
            state_d = CMD;
            cnt_d   = CW'(1);
          end
        end
        CMD: begin
          if (rise) begin
            op_d  = {op_q[0], mosi_s};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
              if (op_d == OP_WR || op_d == OP_RD) begin
                state_d = ADDR;
                cnt_d   = CW'(ADDR_WIDTH - 1);
              end else begin
                state_d = DRAIN;
                err_inc = 1'b1;
              end
            end
          end
        end
        ADDR: begin
          if (rise) begin
            addr_sh_d = {addr_sh_q[ADDR_WIDTH-2:0], mosi_s};
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == '0) begin
              state_d = PAD;
              if (op_q == OP_RD) begin
                rd_en_d = 1'b1;
                addr_d  = addr_sh_d;
              end
            end
          end
        end
        PAD: begin
          if (rise) begin
            state_d = DATA;
            cnt_d   = CW'(DATA_WIDTH - 1);
            miso_d  = 1'b0;
          end
        end
        DATA: begin
          if (rise) begin
            data_sh_d = {data_sh_q[DATA_WIDTH-3:0], mosi_s};
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == '0) begin
              state_d = DRAIN;
              if (op_q == OP_WR) begin
                wr_en_d = 1'b1;
                addr_d  = addr_sh_q;
                wdata_d = {data_sh_q, mosi_s};
              end
            end
          end
          if (fall && op_q == OP_RD) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        DRAIN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 2'b00;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
    end
  end

  assign spi_miso  = miso_q & (state_q == DATA) & (op_q == OP_RD);
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

`ifdef SPI_TARGET_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'h00;
    end else if (err_inc && err_q != 8'hFF) begin
      err_q <= err_q + 8'h01;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
`endif

endmodule

// File: tb/tb_spi_target_sync.sv
// Randomized self-checking bench for spi_target_sync: SPI host driver, register responder
// and a frame-level model of expected strobes, MISO bits and error count.
module tb_spi_target_sync;
  localparam int AW = 8;
  localparam int DW = 18;
  localparam int FW = DW + AW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_csn = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso, reg_wr_en, reg_rd_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata = '0;
`ifdef SPI_TARGET_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_target_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
`ifdef SPI_TARGET_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] mem [256];
  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            exp_err = 0;
  int            n_wr = 0;
  int            n_rd = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file: data is only valid in the single cycle after the read strobe.
  always @(negedge clk) reg_rdata = reg_rd_en ? mem[reg_addr] : DW'($urandom);

  wr_t           cw;
  logic [AW-1:0] ca;
  always @(negedge clk) begin
    if (chk_en) begin
      if (reg_wr_en) begin
        n_wr++;
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL wr_strobe: got unexpected write addr %0h data %0h, none required", reg_addr, reg_wdata);
        end else begin
          cw = wq.pop_front();
          chk("wr_addr", reg_addr, cw.a);
          chk("wr_data", reg_wdata, cw.d);
          exp_addr  = cw.a;
          exp_wdata = cw.d;
        end
      end
      if (reg_rd_en) begin
        n_rd++;
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL rd_strobe: got unexpected read addr %0h, none required", reg_addr);
        end else begin
          ca = rq.pop_front();
          chk("rd_addr", reg_addr, ca);
          exp_addr = ca;
        end
      end
      chk("addr_hold", reg_addr, exp_addr);
      chk("wdata_hold", reg_wdata, exp_wdata);
    end
  end

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One host frame: nbits SCK pulses, optional CSN rise together with the last
  // SCK rise, optional reset pulse after SCK rise number rst_at.
  task automatic frame(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int nbits, input bit csn_last, input int rst_at,
                       output logic [DW-1:0] rx);
    logic [FW-1:0] fr;
    int  half;
    bit  valid, is_rd, live;
    fr    = {op, a, 1'($urandom), d};
    valid = (op == 2'b10) || (op == 2'b01);
    is_rd = (op == 2'b01);
    live  = 1'b1;
    rx    = '0;
    half  = 5 * $urandom_range(9, 16);
    if (rst_at < 0) begin
      if (op == 2'b10 && nbits == FW && !csn_last) wq.push_back('{a: a, d: d});
      if (is_rd && nbits >= 2 + AW) rq.push_back(a);
      if (!valid && nbits >= 2) exp_err = sat_inc(exp_err);
      else if (nbits < FW || csn_last) exp_err = sat_inc(exp_err);
    end
    spi_csn = 1'b0;
    #(half);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = fr[FW-1-i];
      #(half);
      if (live && is_rd && i >= 3 + AW) begin
        rx[DW-1-(i-3-AW)] = spi_miso;
        chk("miso_data", spi_miso, mem[a][DW-1-(i-3-AW)]);
      end else begin
        chk("miso_zero", spi_miso, 0);
      end
      if (csn_last && i == nbits - 1) spi_csn = 1'b1;
      spi_clk = 1'b1;
      if (i == rst_at) begin
        #25;
        rst_n     = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_err   = 0;
        #1;
        chk("rst_miso", spi_miso, 0);
        chk("rst_wr", reg_wr_en, 0);
        chk("rst_rd", reg_rd_en, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
`ifdef SPI_TARGET_ERR_CNT_EN
        chk("rst_err", err_cnt, 0);
`endif
        #20;
        rst_n = 1'b1;
        live  = 1'b0;
      end
      #(half);
      spi_clk = 1'b0;
    end
    #(half);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    #100;
    chk("miso_after_csn", spi_miso, 0);
`ifdef SPI_TARGET_ERR_CNT_EN
    chk("err_cnt", err_cnt, exp_err);
`endif
  endtask

  logic [DW-1:0] rx;
  logic [1:0]    rop;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdat;
  int            rbits, rsel;

  initial begin
    #1;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[5] = 18'h2A5A5;
    #50;
    chk("reset_miso", spi_miso, 0);
    chk("reset_wr", reg_wr_en, 0);
    chk("reset_rd", reg_rd_en, 0);
    chk("reset_addr", reg_addr, 0);
    chk("reset_wdata", reg_wdata, 0);
`ifdef SPI_TARGET_ERR_CNT_EN
    chk("reset_err", err_cnt, 0);
`endif
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #100;

    frame(2'b10, 8'h00, 18'h00001, FW, 1'b0, -1, rx);
    chk("t1_nwr", n_wr, 1);
    chk("t1_nrd", n_rd, 0);
    chk("t1_addr", reg_addr, 8'h00);
    chk("t1_wdata", reg_wdata, 18'h00001);

    frame(2'b10, 8'h00, 18'h20001, FW, 1'b0, -1, rx);
    chk("t2_nwr", n_wr, 2);
    chk("t2_wdata", reg_wdata, 18'h20001);

    frame(2'b01, 8'h05, DW'($urandom), FW, 1'b0, -1, rx);
    chk("t3_rx", rx, 18'h2A5A5);
    chk("t3_nrd", n_rd, 1);
    chk("t3_addr", reg_addr, 8'h05);

    frame(2'b10, 8'h03, 18'h15555, 2 + AW + 1 + 10, 1'b0, -1, rx);
    chk("t4_abort_nwr", n_wr, 2);
    frame(2'b10, 8'h03, 18'h00077, FW, 1'b0, -1, rx);
    chk("t4_nwr", n_wr, 3);
    chk("t4_addr", reg_addr, 8'h03);
    chk("t4_wdata", reg_wdata, 18'h00077);
`ifdef SPI_TARGET_ERR_CNT_EN
    chk("t4_err", err_cnt, 1);
`endif

    frame(2'b11, 8'h07, DW'($urandom), FW, 1'b0, -1, rx);
    chk("t5_nwr", n_wr, 3);
    chk("t5_nrd", n_rd, 1);
`ifdef SPI_TARGET_ERR_CNT_EN
    chk("t5_err", err_cnt, 2);
`endif
    frame(2'b10, 8'h09, 18'h3FFFF, FW, 1'b0, -1, rx);
    chk("t5_next_nwr", n_wr, 4);
    chk("t5_next_wdata", reg_wdata, 18'h3FFFF);

    frame(2'b10, 8'h44, 18'h00123, FW, 1'b1, -1, rx);
    chk("t6_csn_last_nwr", n_wr, 4);
    chk("t6_addr", reg_addr, 8'h09);
`ifdef SPI_TARGET_ERR_CNT_EN
    chk("t6_err", err_cnt, 3);
`endif

    frame(2'b01, 8'h05, 18'h0, FW, 1'b0, 6, rx);
    chk("t7_nrd", n_rd, 1);
    frame(2'b01, 8'h21, DW'($urandom), FW, 1'b0, -1, rx);
    chk("t7_rx", rx, mem[8'h21]);
    chk("t7_nrd_after", n_rd, 2);

    for (int k = 0; k < 40; k++) begin
      rsel  = $urandom_range(0, 9);
      rop   = (rsel == 0) ? 2'b00 : (rsel == 1) ? 2'b11 : (rsel < 6) ? 2'b10 : 2'b01;
      raddr = AW'($urandom);
      rdat  = DW'($urandom);
      rbits = ($urandom_range(0, 4) == 0) ? $urandom_range(0, FW - 1) : FW;
      frame(rop, raddr, rdat, rbits, 1'b0, -1, rx);
      if (rop == 2'b01 && rbits == FW) chk("rand_rx", rx, mem[raddr]);
    end

`ifdef SPI_TARGET_ERR_CNT_EN
    for (int k = 0; k < 260; k++) frame(2'b10, 8'h00, 18'h0, 0, 1'b0, -1, rx);
    chk("err_saturated", err_cnt, 255);
`endif

    #200;
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
